// File: rtl/light_pkg.sv
// Shared constants and types for the light_row block.
// Optional feature macro used by light_row: LIGHT_ROW_WRAP_EN.
package light_pkg;

    // Default parameter values for the light row.
    localparam int unsigned LIGHT_WIDTH_DEF  = 8;
    localparam int unsigned LIGHT_PERIOD_DEF = 4;
    localparam int unsigned SCORE_W_DEF      = 8;

    // Prescale count is wide enough for the largest legal PERIOD (65535).
    localparam int unsigned CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/light_tick.sv
// Prescale counter producing a one-cycle step every PERIOD non-held cycles.
module light_tick
    import light_pkg::*;
#(
    parameter int unsigned PERIOD = LIGHT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    output logic step
);

    localparam cnt_t LAST = cnt_t'(PERIOD - 1);

    cnt_t cnt;

    // Step fires on the last count of each period, never while held.
    assign step = (cnt == LAST) && !hold;

    // Count up every non-held cycle and wrap after the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!hold) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/light_row.sv
// Scrolling row of lights: cells move one place left per step, new cells
// enter at the right end, departures from bit 0 are pulsed and counted.
// Define LIGHT_ROW_WRAP_EN to feed the departing cell back in at the right.
module light_row
    import light_pkg::*;
#(
    parameter int unsigned WIDTH   = LIGHT_WIDTH_DEF,
    parameter int unsigned PERIOD  = LIGHT_PERIOD_DEF,
    parameter int unsigned SCORE_W = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lose,
    input  logic               spawn,
    output logic [WIDTH-1:0]   lights,
    output logic               exit_pulse,
    output logic [SCORE_W-1:0] score
);

    logic               step;
    logic               in_bit;
    logic               pend;
    logic               exit_q;
    logic [WIDTH-1:0]   lights_q;
    logic [SCORE_W-1:0] score_q;

    light_tick #(
        .PERIOD(PERIOD)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .hold (lose),
        .step (step)
    );

`ifdef LIGHT_ROW_WRAP_EN
    // Cell entering at the right end: new request or the cell leaving bit 0.
    always_comb begin
        in_bit = spawn | pend | lights_q[0];
    end
`else
    // Cell entering at the right end: a fresh or remembered spawn request.
    always_comb begin
        in_bit = spawn | pend;
    end
`endif

    // Shift the row on step; remember one spawn request between steps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lights_q <= '0;
            pend     <= 1'b0;
        end else if (step) begin
            lights_q <= {in_bit, lights_q[WIDTH-1:1]};
            pend     <= 1'b0;
        end else if (spawn && !lose) begin
            pend     <= 1'b1;
        end
    end

    // Pulse and count each cell that leaves bit 0; score saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exit_q  <= 1'b0;
            score_q <= '0;
        end else begin
            exit_q <= step && lights_q[0];
            if (step && lights_q[0] && (score_q != '1)) begin
                score_q <= score_q + 1'b1;
            end
        end
    end

    assign lights     = lights_q;
    assign exit_pulse = exit_q;
    assign score      = score_q;

endmodule

// File: tb/tb_light_row.sv
// Self-checking bench for light_row: directed literal scenarios plus
// randomized spawn/lose/reset traffic compared against a behavioural model.
module tb_light_row;

    localparam int unsigned W  = 4;
    localparam int unsigned P  = 3;
    localparam int unsigned SW = 2;

    logic          clk;
    logic          reset;
    logic          lose;
    logic          spawn;
    logic [W-1:0]  lights;
    logic          exit_pulse;
    logic [SW-1:0] score;

    int checks   = 0;
    int failures = 0;

    light_row #(
        .WIDTH  (W),
        .PERIOD (P),
        .SCORE_W(SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .lose      (lose),
        .spawn     (spawn),
        .lights    (lights),
        .exit_pulse(exit_pulse),
        .score     (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: row held as an integer, shifted right once per
    // period; the entering cell is OR-ed in at the top bit.
    int m_phase = 0;
    int m_row   = 0;
    int m_pend  = 0;
    int m_exit  = 0;
    int m_score = 0;
    int m_in;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_row   = 0;
            m_pend  = 0;
            m_exit  = 0;
            m_score = 0;
        end else if (lose) begin
            m_exit = 0;
        end else if (m_phase == P - 1) begin
            m_exit = m_row % 2;
            m_in   = (spawn || m_pend) ? 1 : 0;
`ifdef LIGHT_ROW_WRAP_EN
            if (m_exit == 1) m_in = 1;
`endif
            m_row   = (m_row / 2) + m_in * (1 << (W - 1));
            m_pend  = 0;
            m_phase = 0;
            if (m_exit == 1 && m_score < (1 << SW) - 1) m_score = m_score + 1;
        end else begin
            m_phase = m_phase + 1;
            m_exit  = 0;
            if (spawn) m_pend = 1;
        end
    end

    // Every cycle: DUT outputs against the model, away from the clock edge.
    always @(negedge clk) begin
        chk("model_lights", 32'(lights), 32'(m_row));
        chk("model_exit", 32'(exit_pulse), 32'(m_exit));
        chk("model_score", 32'(score), 32'(m_score));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        lose  = 1'b0;
        spawn = 1'b0;
        tick(3);
        chk("reset_lights", 32'(lights), 32'h0);
        chk("reset_exit", 32'(exit_pulse), 32'h0);
        chk("reset_score", 32'(score), 32'h0);

        // One-cycle spawn on a non-step cycle: remembered until the step.
        reset = 1'b0;
        spawn = 1'b1;
        tick(1);
        spawn = 1'b0;
        tick(1);
        chk("no_early_step", 32'(lights), 32'h0);
        tick(1);
        chk("pend_enters", 32'(lights), 32'b1000);
        tick(3);
        chk("shift_1", 32'(lights), 32'b0100);
        tick(1);
        chk("mid_period", 32'(lights), 32'b0100);

        // Freeze with cell at bit 2 and mid-period count; spawns ignored.
        lose = 1'b1;
        for (int i = 0; i < 10; i++) begin
            spawn = 1'($urandom_range(0, 1));
            tick(1);
        end
        chk("lose_lights", 32'(lights), 32'b0100);
        chk("lose_exit", 32'(exit_pulse), 32'h0);
        chk("lose_score", 32'(score), 32'h0);
        lose  = 1'b0;
        spawn = 1'b0;
        tick(1);
        chk("resume_hold", 32'(lights), 32'b0100);
        tick(1);
        chk("resume_step", 32'(lights), 32'b0010);
        tick(3);
        chk("shift_3", 32'(lights), 32'b0001);
        tick(3);
`ifdef LIGHT_ROW_WRAP_EN
        chk("wrap_lights", 32'(lights), 32'b1000);
`else
        chk("exit_lights", 32'(lights), 32'b0000);
`endif
        chk("exit_pulse_hi", 32'(exit_pulse), 32'h1);
        chk("exit_score", 32'(score), 32'h1);
        tick(1);
        chk("exit_pulse_lo", 32'(exit_pulse), 32'h0);

        // Fill the row, leave a request pending, then reset between edges.
        spawn = 1'b1;
        tick(8);
        spawn = 1'b0;
        tick(1);
        #2 reset = 1'b1;
        #1;
        chk("async_lights", 32'(lights), 32'h0);
        chk("async_exit", 32'(exit_pulse), 32'h0);
        chk("async_score", 32'(score), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(P * 3);
        chk("pend_discarded", 32'(lights), 32'h0);

        // Randomized traffic, including occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            spawn = ($urandom_range(0, 2) == 0);
            lose  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/light_row.md
LIGHT_ROW -- requirements
Module: light_row

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of light cells, legal range 2..64.
REQ-002 SHALL have parameter PERIOD, default 4, clock cycles per scroll step, legal range 1..65535.
REQ-003 SHALL have parameter SCORE_W, default 8, width of the score counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port lose  input  1  level; freezes all state while high.
REQ-007 SHALL have port spawn  input  1  request to inject a lit cell at the right end.
REQ-008 SHALL have port lights  output  WIDTH  cell states; bit 0 = leftmost, bit WIDTH-1 = rightmost.
REQ-009 SHALL have port exit_pulse  output  1  one-cycle pulse when a lit cell leaves bit 0.
REQ-010 SHALL have port score  output  SCORE_W  count of exits, saturating.

Function
REQ-011 SHALL keep a prescale counter cnt in 0..PERIOD-1, incrementing every non-frozen cycle and wrapping to 0 after PERIOD-1.
REQ-012 SHALL define step = (cnt == PERIOD-1) && !lose; with PERIOD=1, step is asserted on every non-frozen cycle.
REQ-013 On step, SHALL update lights[i] <= lights[i+1] for i in 0..WIDTH-2.
REQ-014 On step, SHALL set lights[WIDTH-1] <= spawn || pend, then clear pend.
REQ-015 SHALL set pend on a non-step cycle with spawn=1 and lose=0; pend SHALL hold a single request, so further spawns coalesce.
REQ-016 While lose=1, SHALL hold cnt, lights, pend and score, ignore spawn, and drive exit_pulse=0.
REQ-017 SHALL register exit_pulse=1 in the cycle after a step in which the pre-step lights[0]=1; otherwise exit_pulse=0.
REQ-018 SHALL increment score by 1 on each exit_pulse; at 2^SCORE_W-1 it SHALL saturate with no wrap.
REQ-019 Lights SHALL change only on step; no cell remains lit longer than one step interval unless lose is asserted.

Reset
REQ-020 Reset SHALL asynchronously force cnt=0, lights=0, pend=0, exit_pulse=0 and score=0.
REQ-021 Reset SHALL override lose and spawn.
REQ-022 Reset asserted mid-step SHALL discard any pending spawn.
REQ-023 After release, the first step SHALL occur PERIOD cycles later.

Configuration
REQ-024 With macro LIGHT_ROW_WRAP_EN defined, step SHALL set lights[WIDTH-1] <= lights[0] || spawn || pend, so a lit cell re-enters at the right.
REQ-025 With LIGHT_ROW_WRAP_EN defined, exit_pulse and score SHALL still count each departure from bit 0.
REQ-026 Without LIGHT_ROW_WRAP_EN, a cell leaving bit 0 SHALL be discarded as in REQ-014.

Structure
REQ-027 Package light_pkg SHALL hold the default constants LIGHT_WIDTH_DEF=8, LIGHT_PERIOD_DEF=4 and SCORE_W_DEF=8.
REQ-028 Package light_pkg SHALL hold the typedef for the prescale count width.
REQ-029 Sub-module light_tick SHALL implement the prescale counter and step generation with inputs clk, reset, hold and output step.
REQ-030 light_row SHALL instantiate light_tick once and contain the shift, pend and score logic.

Verification
REQ-031 Scenario: WIDTH=4, PERIOD=1, a one-cycle spawn pulse, lose=0 -> lights sequence 1000, 0100, 0010, 0001 (bit3..bit0), then 0000 with exit_pulse=1 for one cycle and score=1.
REQ-032 Scenario: PERIOD=4, spawn in cycle 1 (non-step) -> pend set; lights[WIDTH-1]=1 after the step at cycle 3; pend cleared.
REQ-033 Scenario: lit cell at bit 2, lose=1 held for 10 cycles with spawn pulses -> lights, cnt and score unchanged; exit_pulse=0; after lose falls, stepping resumes from the held cnt.
REQ-034 Scenario: SCORE_W=2, 5 exits -> score goes 1,2,3,3,3.
REQ-035 Scenario: reset asserted asynchronously between clock edges with lights=0110 -> outputs are 0 immediately; first step occurs PERIOD cycles after release.
REQ-036 Scenario: with LIGHT_ROW_WRAP_EN, WIDTH=4, PERIOD=1, one spawn -> the cell circulates 1000, 0100, 0010, 0001, 1000; exit_pulse fires once per lap.
